scarv_cop_rsp_queue: RTL and testbench

- Response-side counterpart of the coprocessor instruction decoder. The decoder consumes encoded instructions arriving from the CPU; this block returns completed results to the CPU over the COP response channel.
- Tracks in-flight instructions with a credit counter and buffers functional-unit results in an in-order FIFO.
- Applies exception masking before presenting results on a valid/ready handshake.
- Sits between the coprocessor functional-unit writeback mux and the CPU response port.

---
 rtl/scarv_cop_rsp_queue.sv | 120 ++++++++++++
 tb/tb_scarv_cop_rsp_queue.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scarv_cop_rsp_queue.sv
// COP response queue: counts in-flight instructions with credits, buffers masked
// functional-unit results in an in-order FIFO and returns them to the CPU.
module scarv_cop_rsp_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic        fu_rsp_valid,
  output logic        fu_rsp_ready,
  input  logic [4:0]  fu_rsp_rd,
  input  logic        fu_rsp_wen,
  input  logic [31:0] fu_rsp_data,
  input  logic [2:0]  fu_rsp_status,
  output logic        cpu_rsp_valid,
  input  logic        cpu_rsp_ready,
  output logic [4:0]  cpu_rsp_rd,
  output logic        cpu_rsp_wen,
  output logic [31:0] cpu_rsp_data,
  output logic [2:0]  cpu_rsp_status,
  output logic        cop_busy,
  output logic        proto_err
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] data;
    logic [2:0]  status;
  } rsp_t;

  rsp_t          mem_q [DEPTH];
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] credits_q, credits_d;
  logic          proto_err_q, proto_err_d;

  logic          empty, full;
  logic [CW-1:0] occupancy;
  logic          issue_fire, push_fire, pop_fire;
  rsp_t          push_entry, head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[CW-1] != rd_ptr_q[CW-1]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign occupancy = wr_ptr_q - rd_ptr_q;

  assign issue_ready  = (credits_q < CW'(DEPTH));
  assign fu_rsp_ready = !full;
  assign cop_busy     = (credits_q != '0);
  assign proto_err    = proto_err_q;

  assign issue_fire = issue_valid && issue_ready;
  assign push_fire  = fu_rsp_valid && fu_rsp_ready;
  assign pop_fire   = cpu_rsp_valid && cpu_rsp_ready;

  // Faulted results never write a GPR, and non-writing results carry no data.
  always_comb begin
    push_entry.rd     = fu_rsp_rd;
    push_entry.status = fu_rsp_status;
    push_entry.wen    = 1'b0;
    push_entry.data   = '0;
    if (fu_rsp_status == 3'd0) begin
      push_entry.wen  = fu_rsp_wen;
      push_entry.data = fu_rsp_wen ? fu_rsp_data : 32'd0;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    wr_ptr_d    = wr_ptr_q + CW'(push_fire);
    rd_ptr_d    = rd_ptr_q + CW'(pop_fire);
    credits_d   = credits_q;
    proto_err_d = proto_err_q;
    case ({issue_fire, pop_fire})
      2'b10:   credits_d = credits_q + CW'(1);
      2'b01:   if (credits_q != '0) credits_d = credits_q - CW'(1);
      default: credits_d = credits_q;
    endcase
    if (fu_rsp_valid && (occupancy >= credits_q))
      proto_err_d = 1'b1;
    if (push_fire && (fu_rsp_status >= 3'd5))
      proto_err_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      credits_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      credits_q   <= credits_d;
      proto_err_q <= proto_err_d;
    end
  end

  // NOTE: storage is not reset; empty pointers make stale entries unobservable.
  always_ff @(posedge g_clk) begin
    if (push_fire)
      mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
  end

  assign head = mem_q[rd_ptr_q[AW-1:0]];

  assign cpu_rsp_valid  = !empty;
  assign cpu_rsp_rd     = empty ? 5'd0  : head.rd;
  assign cpu_rsp_wen    = empty ? 1'b0  : head.wen;
  assign cpu_rsp_data   = empty ? 32'd0 : head.data;
  assign cpu_rsp_status = empty ? 3'd0  : head.status;

endmodule

// File: tb/tb_scarv_cop_rsp_queue.sv
// Bench for scarv_cop_rsp_queue: directed scenarios plus randomized traffic
// checked against a queue-based model of the response channel.
module tb_scarv_cop_rsp_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic        g_clk, g_reset;
  logic        issue_valid, issue_ready;
  logic        fu_rsp_valid, fu_rsp_ready;
  logic [4:0]  fu_rsp_rd;
  logic        fu_rsp_wen;
  logic [31:0] fu_rsp_data;
  logic [2:0]  fu_rsp_status;
  logic        cpu_rsp_valid, cpu_rsp_ready;
  logic [4:0]  cpu_rsp_rd;
  logic        cpu_rsp_wen;
  logic [31:0] cpu_rsp_data;
  logic [2:0]  cpu_rsp_status;
  logic        cop_busy, proto_err;

  int checks = 0;
  int errors = 0;

  scarv_cop_rsp_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .fu_rsp_valid(fu_rsp_valid), .fu_rsp_ready(fu_rsp_ready),
    .fu_rsp_rd(fu_rsp_rd), .fu_rsp_wen(fu_rsp_wen),
    .fu_rsp_data(fu_rsp_data), .fu_rsp_status(fu_rsp_status),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_ready(cpu_rsp_ready),
    .cpu_rsp_rd(cpu_rsp_rd), .cpu_rsp_wen(cpu_rsp_wen),
    .cpu_rsp_data(cpu_rsp_data), .cpu_rsp_status(cpu_rsp_status),
    .cop_busy(cop_busy), .proto_err(proto_err)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] data;
    logic [2:0]  status;
  } rsp_t;

  rsp_t mq[$];
  int   m_cred;
  bit   m_proto;
  int   n_issue, n_push, n_pop;

  function automatic rsp_t mask_rsp(input logic [4:0] rd, input logic wen,
                                    input logic [31:0] d, input logic [2:0] st);
    rsp_t r;
    r.rd     = rd;
    r.status = st;
    r.wen    = (st == 3'd0) ? wen : 1'b0;
    r.data   = (st == 3'd0 && wen) ? d : 32'd0;
    return r;
  endfunction

  function automatic logic [45:0] exp_out();
    rsp_t h;
    logic v;
    h = '0;
    v = (mq.size() > 0);
    if (v) h = mq[0];
    return {v, h.rd, h.wen, h.data, h.status, logic'(m_cred < DEPTH),
            logic'(mq.size() < DEPTH), logic'(m_cred != 0), logic'(m_proto)};
  endfunction

  function automatic logic [45:0] act_out();
    return {cpu_rsp_valid, cpu_rsp_rd, cpu_rsp_wen, cpu_rsp_data, cpu_rsp_status,
            issue_ready, fu_rsp_ready, cop_busy, proto_err};
  endfunction

  function automatic logic [41:0] act_rsp();
    return {cpu_rsp_valid, cpu_rsp_rd, cpu_rsp_wen, cpu_rsp_data, cpu_rsp_status};
  endfunction

  function automatic void model_clear();
    mq.delete();
    m_cred  = 0;
    m_proto = 0;
    n_issue = 0;
    n_push  = 0;
    n_pop   = 0;
  endfunction

  // Advance one clock with the currently driven inputs and update the model.
  task automatic tick();
    bit issue_f, push_f, pop_f;
    issue_f = issue_valid && (m_cred < DEPTH);
    push_f  = fu_rsp_valid && (mq.size() < DEPTH);
    pop_f   = cpu_rsp_ready && (mq.size() > 0);
    if (fu_rsp_valid && (mq.size() >= m_cred)) m_proto = 1;
    if (push_f && (fu_rsp_status >= 3'd5)) m_proto = 1;
    @(posedge g_clk);
    #1;
    if (pop_f) begin
      void'(mq.pop_front());
      n_pop++;
    end
    if (push_f) begin
      mq.push_back(mask_rsp(fu_rsp_rd, fu_rsp_wen, fu_rsp_data, fu_rsp_status));
      n_push++;
    end
    if (issue_f) n_issue++;
    if (issue_f && !pop_f) m_cred++;
    else if (pop_f && !issue_f && m_cred > 0) m_cred--;
  endtask

  task automatic idle_inputs();
    issue_valid   = 1'b0;
    fu_rsp_valid  = 1'b0;
    fu_rsp_rd     = '0;
    fu_rsp_wen    = 1'b0;
    fu_rsp_data   = '0;
    fu_rsp_status = '0;
    cpu_rsp_ready = 1'b0;
  endtask

  task automatic set_fu(input logic [4:0] rd, input logic wen,
                        input logic [31:0] d, input logic [2:0] st);
    fu_rsp_valid  = 1'b1;
    fu_rsp_rd     = rd;
    fu_rsp_wen    = wen;
    fu_rsp_data   = d;
    fu_rsp_status = st;
  endtask

  task automatic do_reset();
    idle_inputs();
    g_reset = 1'b1;
    model_clear();
    @(posedge g_clk);
    #1;
    g_reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    g_reset = 1'b1;
    model_clear();
    #3;
    checks++;
    if (act_out() !== {1'b0, 5'd0, 1'b0, 32'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got %h want %h", act_out(),
               {1'b0, 5'd0, 1'b0, 32'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0});
    end
    @(posedge g_clk);
    #1;
    g_reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    set_fu(5'd5, 1'b1, 32'hDEAD_BEEF, 3'd0);
    tick();
    fu_rsp_valid = 1'b0;
    checks++;
    if (act_rsp() !== {1'b1, 5'd5, 1'b1, 32'hDEAD_BEEF, 3'd0}) begin
      errors++;
      $display("FAIL single_head got %h want %h", act_rsp(),
               {1'b1, 5'd5, 1'b1, 32'hDEAD_BEEF, 3'd0});
    end
    checks++;
    if (cop_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy got %b want 1", cop_busy);
    end
    cpu_rsp_ready = 1'b1;
    tick();
    cpu_rsp_ready = 1'b0;
    checks++;
    if ({cpu_rsp_valid, cop_busy} !== 2'b00) begin
      errors++;
      $display("FAIL single_drained got valid=%b busy=%b want 0 0", cpu_rsp_valid, cop_busy);
    end
  endtask

  task automatic test_full();
    do_reset();
    issue_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick();
    issue_valid = 1'b0;
    checks++;
    if (issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_issue_ready got %b want 0", issue_ready);
    end
    for (int i = 0; i < DEPTH; i++) begin
      set_fu(5'(i + 1), 1'b1, 32'hA000_0000 + 32'(i), 3'd0);
      tick();
    end
    fu_rsp_valid = 1'b0;
    checks++;
    if (fu_rsp_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_fu_ready got %b want 0", fu_rsp_ready);
    end
    cpu_rsp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if ({cpu_rsp_valid, cpu_rsp_rd, cpu_rsp_data} !== {1'b1, 5'(i + 1), 32'hA000_0000 + 32'(i)}) begin
        errors++;
        $display("FAIL full_drain_order[%0d] got rd=%0d data=%h want rd=%0d data=%h",
                 i, cpu_rsp_rd, cpu_rsp_data, i + 1, 32'hA000_0000 + 32'(i));
      end
      tick();
      if (i == 0) begin
        checks++;
        if (issue_ready !== 1'b1) begin
          errors++;
          $display("FAIL full_issue_ready_after_pop got %b want 1", issue_ready);
        end
      end
    end
    cpu_rsp_ready = 1'b0;
    checks++;
    if ({cpu_rsp_valid, cop_busy} !== 2'b00) begin
      errors++;
      $display("FAIL full_drained got valid=%b busy=%b want 0 0", cpu_rsp_valid, cop_busy);
    end
  endtask

  task automatic test_masking();
    do_reset();
    issue_valid = 1'b1;
    tick();
    tick();
    issue_valid = 1'b0;
    set_fu(5'd7, 1'b1, 32'h0000_1234, 3'd2);
    tick();
    set_fu(5'd9, 1'b0, 32'hCAFE_F00D, 3'd0);
    tick();
    fu_rsp_valid = 1'b0;
    checks++;
    if (act_rsp() !== {1'b1, 5'd7, 1'b0, 32'd0, 3'd2}) begin
      errors++;
      $display("FAIL mask_status got %h want %h", act_rsp(), {1'b1, 5'd7, 1'b0, 32'd0, 3'd2});
    end
    cpu_rsp_ready = 1'b1;
    tick();
    checks++;
    if (act_rsp() !== {1'b1, 5'd9, 1'b0, 32'd0, 3'd0}) begin
      errors++;
      $display("FAIL mask_nowen got %h want %h", act_rsp(), {1'b1, 5'd9, 1'b0, 32'd0, 3'd0});
    end
    tick();
    cpu_rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure_random();
    logic [41:0] prev_rsp;
    bit          prev_stall;
    int          cyc;
    do_reset();
    prev_stall = 0;
    prev_rsp   = '0;
    cyc        = 0;
    while (n_pop < 100 && cyc < 4000) begin
      checks++;
      if (act_out() !== exp_out()) begin
        errors++;
        $display("FAIL rand_outputs cyc=%0d got %h want %h", cyc, act_out(), exp_out());
      end
      if (prev_stall) begin
        checks++;
        if (act_rsp() !== prev_rsp) begin
          errors++;
          $display("FAIL rand_stall_stable cyc=%0d got %h want %h", cyc, act_rsp(), prev_rsp);
        end
      end
      issue_valid   = (n_issue < 100) && ($urandom_range(0, 1) == 1);
      fu_rsp_valid  = (n_push < 100) && (mq.size() < m_cred) && ($urandom_range(0, 2) != 0);
      fu_rsp_rd     = 5'($urandom);
      fu_rsp_wen    = 1'($urandom);
      fu_rsp_data   = $urandom;
      fu_rsp_status = 3'($urandom_range(0, 4));
      cpu_rsp_ready = ($urandom_range(0, 1) == 1);
      prev_stall    = cpu_rsp_valid && !cpu_rsp_ready;
      prev_rsp      = act_rsp();
      tick();
      cyc++;
    end
    idle_inputs();
    checks++;
    if (n_pop != 100) begin
      errors++;
      $display("FAIL rand_delivered got %0d want 100", n_pop);
    end
    checks++;
    if ({cpu_rsp_valid, cop_busy, proto_err} !== 3'b000) begin
      errors++;
      $display("FAIL rand_final got valid=%b busy=%b perr=%b want 0 0 0",
               cpu_rsp_valid, cop_busy, proto_err);
    end
  endtask

  task automatic test_proto_err();
    do_reset();
    set_fu(5'd1, 1'b1, 32'h1111_1111, 3'd0);
    tick();
    fu_rsp_valid = 1'b0;
    checks++;
    if (proto_err !== 1'b1) begin
      errors++;
      $display("FAIL perr_no_credit got %b want 1", proto_err);
    end
    for (int i = 0; i < 50; i++) tick();
    checks++;
    if (proto_err !== 1'b1) begin
      errors++;
      $display("FAIL perr_sticky got %b want 1", proto_err);
    end
    do_reset();
    checks++;
    if (proto_err !== 1'b0) begin
      errors++;
      $display("FAIL perr_cleared got %b want 0", proto_err);
    end
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    set_fu(5'd3, 1'b1, 32'h5555_AAAA, 3'd6);
    tick();
    fu_rsp_valid = 1'b0;
    checks++;
    if ({proto_err, act_rsp()} !== {1'b1, 1'b1, 5'd3, 1'b0, 32'd0, 3'd6}) begin
      errors++;
      $display("FAIL perr_reserved_status got %h want %h", {proto_err, act_rsp()},
               {1'b1, 1'b1, 5'd3, 1'b0, 32'd0, 3'd6});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    issue_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_fu(5'(i + 10), 1'b1, 32'hB000_0000 + 32'(i), 3'd0);
      tick();
    end
    fu_rsp_valid  = 1'b0;
    cpu_rsp_ready = 1'b1;
    #3;
    g_reset = 1'b1;
    model_clear();
    #1;
    checks++;
    if ({cpu_rsp_valid, cop_busy, issue_ready} !== 3'b001) begin
      errors++;
      $display("FAIL rstmid_async got valid=%b busy=%b iready=%b want 0 0 1",
               cpu_rsp_valid, cop_busy, issue_ready);
    end
    @(posedge g_clk);
    #1;
    g_reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (act_out() !== exp_out()) begin
        errors++;
        $display("FAIL rstmid_after cyc=%0d got %h want %h", i, act_out(), exp_out());
      end
    end
    cpu_rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_masking();
    test_backpressure_random();
    test_proto_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
